// File: rtl/multi_voice_counter_pkg.sv
// Shared definitions for the multi-voice drum period counter.
package multi_voice_counter_pkg;

  // Per-channel run state; busy is simply "state == ST_RUN".
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } voice_state_t;

  localparam int DEF_CHANNELS  = 4;
  localparam int DEF_WIDTH     = 15;
  localparam int DEF_LEN_WIDTH = 8;

endpackage

// File: rtl/multi_voice_counter_channel.sv
// One drum voice: counts enabled ticks up to a captured limit, toggles the
// square wave on every wrap and stops itself after a captured number of wraps
// (length 0 means run until retriggered).
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | stopped; count and wave held at 0, waiting for go
//   ST_RUN  | counting enabled ticks, wrapping at limit_q
module voice_channel_counter
  import multi_voice_counter_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int LEN_WIDTH = DEF_LEN_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic                 i_go,
  input  logic [WIDTH-1:0]     i_limit,
  input  logic [LEN_WIDTH-1:0] i_length,
  output logic [WIDTH-1:0]     o_count,
  output logic                 o_wave,
  output logic                 o_busy,
  output logic                 o_done
);

  voice_state_t         r_state;
  logic [WIDTH-1:0]     r_count;
  logic                 r_wave;
  logic [LEN_WIDTH-1:0] r_wraps;
  logic [WIDTH-1:0]     r_limit_q;
  logic [LEN_WIDTH-1:0] r_length_q;
  logic                 r_done;

  logic                 w_at_limit;
  logic [LEN_WIDTH-1:0] w_wraps_next;
  logic                 w_last_wrap;

  // Wrap and auto-stop detection from the captured settings only, so live
  // limit/length bus changes cannot disturb a running voice.
  assign w_at_limit   = (r_count == r_limit_q);
  assign w_wraps_next = r_wraps + LEN_WIDTH'(1);
  assign w_last_wrap  = (r_length_q != '0) && (w_wraps_next == r_length_q);

  // Channel FSM with all datapath registers; go has priority over everything.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_wave     <= 1'b0;
      r_wraps    <= '0;
      r_limit_q  <= '0;
      r_length_q <= '0;
      r_done     <= 1'b0;
    end else if (i_go) begin
      r_state    <= ST_RUN;
      r_limit_q  <= i_limit;
      r_length_q <= i_length;
      r_count    <= '0;
      r_wave     <= 1'b0;
      r_wraps    <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (i_en) begin
            if (!w_at_limit) begin
              r_count <= r_count + WIDTH'(1);
            end else if (w_last_wrap) begin
              r_state <= ST_IDLE;
              r_count <= '0;
              r_wave  <= 1'b0;
              r_wraps <= w_wraps_next;
              r_done  <= 1'b1;
            end else begin
              r_count <= '0;
              r_wave  <= ~r_wave;
              r_wraps <= w_wraps_next;
            end
          end
        end
        default: begin
          r_count <= '0;
          r_wave  <= 1'b0;
        end
      endcase
    end
  end

  assign o_count = r_count;
  assign o_wave  = r_wave;
  assign o_busy  = (r_state == ST_RUN);
  assign o_done  = r_done;

endmodule

// File: rtl/multi_voice_counter.sv
// Multi-voice period counter: one independent voice_channel_counter per drum
// voice, with flat per-channel buses and a shared tick enable.
module multi_voice_counter
  import multi_voice_counter_pkg::*;
#(
  parameter int CHANNELS  = DEF_CHANNELS,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int LEN_WIDTH = DEF_LEN_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [CHANNELS-1:0]           go,
  input  logic [CHANNELS*WIDTH-1:0]     limit,
  input  logic [CHANNELS*LEN_WIDTH-1:0] length,
  output logic [CHANNELS*WIDTH-1:0]     count,
  output logic [CHANNELS-1:0]           wave,
  output logic [CHANNELS-1:0]           busy,
  output logic [CHANNELS-1:0]           done
);

  // One channel per voice; channel g owns slice g of every bus.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_voice
    voice_channel_counter #(
      .WIDTH     (WIDTH),
      .LEN_WIDTH (LEN_WIDTH)
    ) u_voice (
      .i_clk    (clk),
      .i_rst    (reset),
      .i_en     (en),
      .i_go     (go[g]),
      .i_limit  (limit[g*WIDTH +: WIDTH]),
      .i_length (length[g*LEN_WIDTH +: LEN_WIDTH]),
      .o_count  (count[g*WIDTH +: WIDTH]),
      .o_wave   (wave[g]),
      .o_busy   (busy[g]),
      .o_done   (done[g])
    );
  end

endmodule

// File: tb/tb_multi_voice_counter.sv
// Scoreboard bench: expected per-edge outputs are queued when a voice is
// triggered and compared on the falling edge after the edge they belong to.
module tb_multi_voice_counter;

  localparam int CH = 4;
  localparam int W  = 15;
  localparam int LW = 8;

  logic               clk   = 1'b0;
  logic               reset = 1'b0;
  logic               en    = 1'b0;
  logic [CH-1:0]      go    = '0;
  logic [CH*W-1:0]    limit = '0;
  logic [CH*LW-1:0]   length = '0;
  logic [CH*W-1:0]    count;
  logic [CH-1:0]      wave;
  logic [CH-1:0]      busy;
  logic [CH-1:0]      done;

  multi_voice_counter #(
    .CHANNELS  (CH),
    .WIDTH     (W),
    .LEN_WIDTH (LW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .go     (go),
    .limit  (limit),
    .length (length),
    .count  (count),
    .wave   (wave),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    string tag;
    int    cyc;
    int    ch;
    int    kind;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic string kname(input int kind);
    case (kind)
      0:       return "count";
      1:       return "wave";
      2:       return "busy";
      default: return "done";
    endcase
  endfunction

  function automatic int observe(input int ch, input int kind);
    case (kind)
      0:       return int'(count[ch*W +: W]);
      1:       return int'(wave[ch]);
      2:       return int'(busy[ch]);
      default: return int'(done[ch]);
    endcase
  endfunction

  // Compare every queued expectation that belongs to the edge just taken.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= edge_n) begin
        if (sb[i].cyc == edge_n)
          check_val(sb[i].tag, observe(sb[i].ch, sb[i].kind), sb[i].val);
        else
          check_val({sb[i].tag, " stale"}, sb[i].cyc, edge_n);
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input string what, input int ch, input int cyc,
                           input int kind, input int val);
    exp_t e;
    e.tag  = $sformatf("%s ch%0d e%0d %s", what, ch, cyc, kname(kind));
    e.cyc  = cyc;
    e.ch   = ch;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  // Expected outputs k edges after go, with en continuously high.
  task automatic push_run(input string what, input int ch, input int e0,
                          input int lim, input int len, input int k0, input int k1);
    int p, fin;
    p   = lim + 1;
    fin = len * p;
    for (int k = k0; k <= k1; k++) begin
      if (len != 0 && k >= fin) begin
        expect_at(what, ch, e0 + k, 0, 0);
        expect_at(what, ch, e0 + k, 1, 0);
        expect_at(what, ch, e0 + k, 2, 0);
        expect_at(what, ch, e0 + k, 3, (k == fin) ? 1 : 0);
      end else begin
        expect_at(what, ch, e0 + k, 0, k % p);
        expect_at(what, ch, e0 + k, 1, (k / p) % 2);
        expect_at(what, ch, e0 + k, 2, 1);
        expect_at(what, ch, e0 + k, 3, 0);
      end
    end
  endtask

  task automatic set_ch(input int ch, input int lim, input int len);
    limit[ch*W +: W]     = W'(lim);
    length[ch*LW +: LW]  = LW'(len);
  endtask

  task automatic fire(input logic [CH-1:0] m);
    go = m;
    @(negedge clk);
    go = '0;
  endtask

  task automatic wait_until(input int cyc);
    while (edge_n < cyc) @(negedge clk);
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (sb.size() != 0 && b < 300) begin
      @(negedge clk);
      b++;
    end
    if (sb.size() != 0) begin
      check_val("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout edge=%0d", edge_n);
    $fatal(1, "timeout");
  end

  initial begin
    int e, e2;
    en = 1'b1;
    #1 reset = 1'b1;
    #2;
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < 4; k++)
        check_val($sformatf("reset ch%0d %s", c, kname(k)), observe(c, k), 0);
    end
    @(negedge clk);
    reset = 1'b0;

    // Basic run: limit 3, length 2.
    set_ch(0, 3, 2);
    e = edge_n + 1;
    push_run("basic", 0, e, 3, 2, 0, 10);
    fire(4'b0001);
    drain();

    // Free run with mid-period retrigger.
    set_ch(1, 1, 0);
    e  = edge_n + 1;
    e2 = e + 3;
    push_run("free", 1, e, 1, 0, 0, 2);
    push_run("retrig", 1, e2, 1, 0, 0, 9);
    fire(4'b0010);
    wait_until(e2 - 1);
    fire(4'b0010);
    drain();
    do_reset();

    // Asynchronous reset mid-run.
    set_ch(0, 10, 0);
    e = edge_n + 1;
    push_run("prerst", 0, e, 10, 0, 0, 6);
    fire(4'b0001);
    wait_until(e + 7);
    check_val("midrun count", observe(0, 0), 7);
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < 4; k++)
      check_val($sformatf("async_rst %s", kname(k)), observe(0, k), 0);
    @(negedge clk);
    reset = 1'b0;

    // en gating: en low for edges e+3..e+5 while count is 2.
    set_ch(2, 5, 0);
    e = edge_n + 1;
    for (int k = 0; k <= 14; k++) begin
      int t;
      t = (k <= 2) ? k : ((k <= 5) ? 2 : k - 3);
      expect_at("engate", 2, e + k, 0, t % 6);
      expect_at("engate", 2, e + k, 1, (t / 6) % 2);
      expect_at("engate", 2, e + k, 2, 1);
      expect_at("engate", 2, e + k, 3, 0);
    end
    fire(4'b0100);
    wait_until(e + 2);
    en = 1'b0;
    wait_until(e + 5);
    en = 1'b1;
    drain();
    do_reset();

    // limit 0: toggle every enabled cycle, stop after 4 wraps.
    set_ch(3, 0, 4);
    e = edge_n + 1;
    push_run("lim0", 3, e, 0, 4, 0, 6);
    fire(4'b1000);
    drain();

    // go coincident with the final wrap: restart wins, no done.
    set_ch(0, 2, 2);
    e  = edge_n + 1;
    e2 = e + 6;
    push_run("coinc_a", 0, e, 2, 2, 0, 5);
    push_run("coinc_b", 0, e2, 2, 2, 0, 7);
    fire(4'b0001);
    wait_until(e2 - 1);
    fire(4'b0001);
    drain();

    // Independent channels on one trigger edge; live limit[1] change ignored.
    set_ch(0, 2, 3);
    set_ch(1, 3, 2);
    set_ch(2, 4, 2);
    set_ch(3, 5, 1);
    e = edge_n + 1;
    push_run("indep", 0, e, 2, 3, 0, 12);
    push_run("indep", 1, e, 3, 2, 0, 12);
    push_run("indep", 2, e, 4, 2, 0, 12);
    push_run("indep", 3, e, 5, 1, 0, 12);
    fire(4'b1111);
    wait_until(e + 2);
    set_ch(1, 7, 1);
    drain();
    e = edge_n + 1;
    push_run("indep_re", 1, e, 7, 1, 0, 9);
    fire(4'b0010);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
